toggle_event_decoder: RTL and testbench

//  Receive-side decoder for a T-flip-flop toggle line. The sender toggles t_in once per event.

---
 rtl/toggle_event_decoder.sv | 130 +++++++++++++
 tb/tb_toggle_event_decoder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder
//   Receive-side decoder for a toggle-encoded event line. t_in is synchronised
//   into clk, each level change becomes a one-cycle pulse, and detected events
//   are buffered in a saturating pending counter drained by valid/ready.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   t_in       toggle line from the sender (asynchronous to clk)
//   evt_ready  consumer accepts one pending event
//   clr_ovf    synchronous clear of the ovf sticky flag
//   evt_pulse  one-cycle pulse per detected toggle
//   evt_valid  pending != 0
//   pending    events detected but not yet consumed (saturates at all-ones)
//   evt_count  total events detected since reset, wrapping
//   level      synchronised t_in level
//   level_b    inverse of level
//   ovf        sticky: toggle detected while pending was full
//
// State | Meaning
// ------+---------------------------------------------------------------
// INIT  | filling the sync chain; last edge loads level without an event
// RUN   | compare sync output against level, one event per difference
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              t_in,
    input  logic              evt_ready,
    input  logic              clr_ovf,
    output logic              evt_pulse,
    output logic              evt_valid,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  evt_count,
    output logic              level,
    output logic              level_b,
    output logic              ovf
);

    localparam logic [PEND_W-1:0] MAX_PEND  = '1;
    localparam int                INIT_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(SYNC_STAGES);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [INIT_W-1:0]      init_cnt, init_cnt_nxt;
    logic                   sync_last;
    logic                   toggle;
    logic                   consume;
    logic                   level_nxt;
    logic [PEND_W-1:0]      pending_nxt;
    logic [CNT_W-1:0]       count_nxt;
    logic                   ovf_nxt;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign evt_valid = (pending != '0);
    assign level_b   = ~level;
    assign consume   = evt_valid & evt_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            init_cnt  <= INIT_LOAD;
            sync_q    <= '0;
            level     <= 1'b0;
            evt_pulse <= 1'b0;
            pending   <= '0;
            evt_count <= '0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_cnt_nxt;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], t_in};
            level     <= level_nxt;
            evt_pulse <= toggle;
            pending   <= pending_nxt;
            evt_count <= count_nxt;
            ovf       <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        level_nxt    = level;
        toggle       = 1'b0;

        case (state)
            ST_INIT: begin
                // Down-count the chain fill; the terminal edge adopts the
                // current line level silently so a preset t_in is not an event.
                if (init_cnt == '0) begin
                    level_nxt = sync_last;
                    state_nxt = ST_RUN;
                end else begin
                    init_cnt_nxt = init_cnt - INIT_W'(1);
                end
            end
            ST_RUN: begin
                toggle    = sync_last ^ level;
                level_nxt = sync_last;
            end
            default: state_nxt = ST_INIT;
        endcase

        pending_nxt = pending;
        ovf_nxt     = clr_ovf ? 1'b0 : ovf;
        // Simultaneous toggle and consume cancel out, even when full.
        if (toggle && !consume) begin
            if (pending == MAX_PEND) begin
                ovf_nxt = 1'b1;
            end else begin
                pending_nxt = pending + PEND_W'(1);
            end
        end else if (!toggle && consume) begin
            pending_nxt = pending - PEND_W'(1);
        end

        count_nxt = evt_count + CNT_W'(toggle);
    end

endmodule

// File: tb/tb_toggle_event_decoder.sv
module tb_toggle_event_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        t_in;
    logic        evt_ready;
    logic        clr_ovf;
    logic        evt_pulse;
    logic        evt_valid;
    logic [3:0]  pending;
    logic [15:0] evt_count;
    logic        level;
    logic        level_b;
    logic        ovf;

    logic        reset2;
    logic        t_in2;
    logic        evt_ready2;
    logic        clr_ovf2;
    logic        evt_pulse2;
    logic        evt_valid2;
    logic [3:0]  pending2;
    logic [3:0]  evt_count2;
    logic        level2;
    logic        level_b2;
    logic        ovf2;

    int checks = 0;
    int errors = 0;
    int pulse_tally = 0;

    toggle_event_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .t_in      (t_in),
        .evt_ready (evt_ready),
        .clr_ovf   (clr_ovf),
        .evt_pulse (evt_pulse),
        .evt_valid (evt_valid),
        .pending   (pending),
        .evt_count (evt_count),
        .level     (level),
        .level_b   (level_b),
        .ovf       (ovf)
    );

    toggle_event_decoder #(.CNT_W(4)) dut_w4 (
        .clk       (clk),
        .reset     (reset2),
        .t_in      (t_in2),
        .evt_ready (evt_ready2),
        .clr_ovf   (clr_ovf2),
        .evt_pulse (evt_pulse2),
        .evt_valid (evt_valid2),
        .pending   (pending2),
        .evt_count (evt_count2),
        .level     (level2),
        .level_b   (level_b2),
        .ovf       (ovf2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired: time %0t required finish earlier", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic lvl);
        reset     = 1'b1;
        t_in      = lvl;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        step();
        reset = 1'b0;
        repeat (3) step();
    endtask

    task automatic toggle_and_wait();
        t_in = ~t_in;
        repeat (4) begin
            step();
            if (evt_pulse) pulse_tally++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; reset2 = 1'b0;
        t_in = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0;
        t_in2 = 1'b0; evt_ready2 = 1'b0; clr_ovf2 = 1'b0;
        #2;
        reset = 1'b1; reset2 = 1'b1;
        #1;
        checks++;
        if ({evt_pulse, evt_valid, pending, evt_count, level, level_b, ovf} !== {1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got pulse=%b valid=%b pend=%0d cnt=%0d lvl=%b lvl_b=%b ovf=%b want 0 0 0 0 0 1 0",
                     evt_pulse, evt_valid, pending, evt_count, level, level_b, ovf);
        end
        step();
        reset = 1'b0;
        pulse_tally = 0;
        repeat (10) begin
            step();
            if (evt_pulse) pulse_tally++;
        end
        checks++;
        if (pulse_tally !== 0) begin
            errors++;
            $display("FAIL idle_pulses: got %0d want 0", pulse_tally);
        end
        checks++;
        if ({evt_valid, pending, evt_count, level, level_b, ovf} !== {1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL idle_state: got valid=%b pend=%0d cnt=%0d lvl=%b lvl_b=%b ovf=%b want 0 0 0 0 1 0",
                     evt_valid, pending, evt_count, level, level_b, ovf);
        end
    endtask

    task automatic test_single_toggle();
        logic [3:0] seen;
        do_reset(1'b0);
        t_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            seen[i] = evt_pulse;
            if (i == 2) begin
                checks++;
                if ({pending, evt_count, level, level_b, evt_valid} !== {4'd1, 16'd1, 1'b1, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL single_state: got pend=%0d cnt=%0d lvl=%b lvl_b=%b valid=%b want 1 1 1 0 1",
                             pending, evt_count, level, level_b, evt_valid);
                end
            end
        end
        checks++;
        if (seen !== 4'b0100) begin
            errors++;
            $display("FAIL single_latency: pulse per edge n..n+3 got %b want 0100 (msb=n+3)", seen);
        end
    endtask

    task automatic test_burst_drain();
        do_reset(1'b0);
        pulse_tally = 0;
        repeat (5) toggle_and_wait();
        checks++;
        if ({pulse_tally[3:0], pending, evt_count, evt_valid} !== {4'd5, 4'd5, 16'd5, 1'b1}) begin
            errors++;
            $display("FAIL burst: got pulses=%0d pend=%0d cnt=%0d valid=%b want 5 5 5 1",
                     pulse_tally, pending, evt_count, evt_valid);
        end
        evt_ready = 1'b1;
        repeat (5) step();
        checks++;
        if ({pending, evt_valid} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL drain: got pend=%0d valid=%b want 0 0", pending, evt_valid);
        end
        step();
        evt_ready = 1'b0;
        checks++;
        if (pending !== 4'd0) begin
            errors++;
            $display("FAIL ready_when_empty: got pend=%0d want 0", pending);
        end
    endtask

    task automatic test_overflow();
        do_reset(1'b0);
        repeat (15) toggle_and_wait();
        checks++;
        if ({pending, ovf} !== {4'd15, 1'b0}) begin
            errors++;
            $display("FAIL full_no_ovf: got pend=%0d ovf=%b want 15 0", pending, ovf);
        end
        toggle_and_wait();
        checks++;
        if ({pending, ovf, evt_count} !== {4'd15, 1'b1, 16'd16}) begin
            errors++;
            $display("FAIL overflow: got pend=%0d ovf=%b cnt=%0d want 15 1 16", pending, ovf, evt_count);
        end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++;
        if ({pending, ovf} !== {4'd15, 1'b0}) begin
            errors++;
            $display("FAIL clr_ovf: got pend=%0d ovf=%b want 15 0", pending, ovf);
        end
    endtask

    // Continues from pending=15, ovf=0, evt_count=16.
    task automatic test_full_toggle_consume();
        t_in = ~t_in;
        repeat (2) step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        checks++;
        if ({evt_pulse, pending, ovf, evt_count} !== {1'b1, 4'd15, 1'b0, 16'd17}) begin
            errors++;
            $display("FAIL full_toggle_consume: got pulse=%b pend=%0d ovf=%b cnt=%0d want 1 15 0 17",
                     evt_pulse, pending, ovf, evt_count);
        end
        t_in = ~t_in;
        repeat (2) step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++;
        if ({ovf, pending, evt_count} !== {1'b1, 4'd15, 16'd18}) begin
            errors++;
            $display("FAIL ovf_beats_clr: got ovf=%b pend=%0d cnt=%0d want 1 15 18", ovf, pending, evt_count);
        end
    endtask

    task automatic test_reset_cases();
        reset = 1'b1;
        t_in  = 1'b1;
        step();
        reset = 1'b0;
        pulse_tally = 0;
        step();
        step();
        checks++;
        if (level !== 1'b0) begin
            errors++;
            $display("FAIL init_hold: level after 2 edges got %b want 0", level);
        end
        step();
        if (evt_pulse) pulse_tally++;
        checks++;
        if ({level, level_b} !== 2'b10) begin
            errors++;
            $display("FAIL init_load: got lvl=%b lvl_b=%b want 1 0", level, level_b);
        end
        repeat (8) begin
            step();
            if (evt_pulse) pulse_tally++;
        end
        checks++;
        if ({pulse_tally[3:0], pending, evt_count} !== {4'd0, 4'd0, 16'd0}) begin
            errors++;
            $display("FAIL preset_high: got pulses=%0d pend=%0d cnt=%0d want 0 0 0", pulse_tally, pending, evt_count);
        end
        toggle_and_wait();
        t_in = 1'b1;
        step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({evt_pulse, evt_valid, pending, evt_count, level, level_b, ovf} !== {1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got pulse=%b valid=%b pend=%0d cnt=%0d lvl=%b lvl_b=%b ovf=%b want 0 0 0 0 0 1 0",
                     evt_pulse, evt_valid, pending, evt_count, level, level_b, ovf);
        end
        step();
        reset = 1'b0;
        pulse_tally = 0;
        repeat (10) begin
            step();
            if (evt_pulse) pulse_tally++;
        end
        checks++;
        if ({pulse_tally[3:0], pending, evt_count, level} !== {4'd0, 4'd0, 16'd0, 1'b1}) begin
            errors++;
            $display("FAIL lost_toggle: got pulses=%0d pend=%0d cnt=%0d lvl=%b want 0 0 0 1",
                     pulse_tally, pending, evt_count, level);
        end
    endtask

    task automatic test_count_wrap();
        reset2 = 1'b1;
        t_in2 = 1'b0;
        evt_ready2 = 1'b1;
        clr_ovf2 = 1'b0;
        step();
        reset2 = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 17; i++) begin
            t_in2 = ~t_in2;
            repeat (4) step();
            if (i == 15) begin
                checks++;
                if (evt_count2 !== 4'd0) begin
                    errors++;
                    $display("FAIL wrap_16: got cnt=%0d want 0", evt_count2);
                end
            end
        end
        checks++;
        if ({evt_count2, ovf2, pending2} !== {4'd1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL wrap_17: got cnt=%0d ovf=%b pend=%0d want 1 0 0", evt_count2, ovf2, pending2);
        end
    endtask

    initial begin
        test_reset();
        test_single_toggle();
        test_burst_drain();
        test_overflow();
        test_full_toggle_consume();
        test_reset_cases();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
